// File: rtl/tdc_ram_reader.sv
// tdc_ram_reader: reads one TDC frame out of the channel DPRAM (header at
// address 0, data at 1..N) and streams it on a valid/ready port, then
// completes a 4-phase handshakeFPGA/handshakePC exchange with the writer.
module tdc_ram_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              SYSCLK,
   input  logic              RESET_N,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_data,
   input  logic              handshakeFPGA,
   output logic              handshakePC,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_last,
   input  logic              dout_ready,
   output logic [31:0]       frame_count,
   output logic [31:0]       word_count,
   output logic              busy,
   output logic              len_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_STREAM, S_DRAIN, S_ACK, S_WAIT_DROP
   } state_t;

   state_t                      r_state, w_next;
   logic [ADDR_W-1:0]           r_n;          // data words in this frame
   logic [ADDR_W-1:0]           r_ptr;        // next data address to read
   logic                        r_pend;       // data read issued last cycle
   logic                        r_pend_last;  // ...and it was address N
   logic [1:0][DATA_W-1:0]      r_fifo_data;
   logic [1:0]                  r_fifo_last;
   logic                        r_wr, r_rd;
   logic [1:0]                  r_cnt;
   logic                        r_hs_pc;
   logic [31:0]                 r_frame_cnt, r_word_cnt;
   logic                        r_len_err;

   logic                        w_re;
   logic [ADDR_W-1:0]           w_addr;
   logic                        w_pop, w_push, w_room, w_hdr_over;
   logic [2:0]                  w_occ;
   logic [ADDR_W-1:0]           w_hdr_n;

   assign w_pop      = (r_cnt != 2'd0) && dout_ready;
   assign w_push     = r_pend;
   // A word leaving the FIFO this cycle frees its slot for a new read, which
   // keeps 1 word/cycle with only two entries and one cycle of read latency.
   assign w_occ      = {1'b0, r_cnt} - {2'b0, w_pop} + {2'b0, r_pend};
   assign w_room     = (w_occ < 3'd2);
   assign w_hdr_over = |ram_data[DATA_W-1:ADDR_W];
   assign w_hdr_n    = w_hdr_over ? {ADDR_W{1'b1}} : ram_data[ADDR_W-1:0];

   // Next-state and DPRAM read-port control.
   always_comb begin
      w_next = r_state;
      w_re   = 1'b0;
      w_addr = '0;
      case (r_state)
         S_IDLE: begin
            if (handshakeFPGA) begin
               w_re   = 1'b1;
               w_next = S_HDR;
            end
         end
         S_HDR: w_next = (w_hdr_n == '0) ? S_ACK : S_STREAM;
         S_STREAM: begin
            w_addr = r_ptr;
            if (w_room) begin
               w_re = 1'b1;
               if (r_ptr == r_n) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_cnt == 2'd0 && !r_pend) w_next = S_ACK;
         end
         // Writer already dropped its request: ACK is a single-cycle pulse.
         S_ACK:       w_next = handshakeFPGA ? S_WAIT_DROP : S_IDLE;
         S_WAIT_DROP: if (!handshakeFPGA) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Header capture, read pointer and in-flight read tracking.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_n         <= '0;
         r_ptr       <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_pend      <= w_re && (r_state == S_STREAM);
         r_pend_last <= (r_ptr == r_n);
         if (r_state == S_HDR) begin
            r_n   <= w_hdr_n;
            r_ptr <= {{(ADDR_W-1){1'b0}}, 1'b1};
            if (w_hdr_over) r_len_err <= 1'b1;
         end else if (r_state == S_STREAM && w_re) begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   // Two-entry output FIFO; dout is driven straight from its storage.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_fifo_data <= '0;
         r_fifo_last <= '0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_cnt       <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr] <= ram_data;
            r_fifo_last[r_wr] <= r_pend_last;
            r_wr              <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Acknowledge flag and statistics counters.
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_hs_pc     <= 1'b0;
         r_frame_cnt <= '0;
         r_word_cnt  <= '0;
      end else begin
         r_hs_pc <= (w_next == S_ACK) || (w_next == S_WAIT_DROP);
         if (w_next == S_ACK && r_state != S_ACK) r_frame_cnt <= r_frame_cnt + 32'd1;
         if (w_pop) r_word_cnt <= r_word_cnt + 32'd1;
      end
   end

   // The IDLE read depends on handshakeFPGA, so gate it to keep the port
   // quiet while reset is held.
   assign ram_re      = w_re && RESET_N;
   assign ram_addr    = w_addr;
   assign handshakePC = r_hs_pc;
   assign dout_valid  = (r_cnt != 2'd0);
   assign dout        = r_fifo_data[r_rd];
   assign dout_last   = dout_valid && r_fifo_last[r_rd];
   assign frame_count = r_frame_cnt;
   assign word_count  = r_word_cnt;
   assign busy        = (r_state != S_IDLE);
   assign len_error   = r_len_err;

endmodule

// File: tb/tb_tdc_ram_reader.sv
// tb_tdc_ram_reader: directed frames against a synchronous DPRAM model, with
// a scoreboard of expected {last,data} words pushed when a frame is loaded
// and popped as the reader delivers words.
module tb_tdc_ram_reader;
   logic        SYSCLK = 1'b0;
   logic        RESET_N;
   logic [7:0]  ram_addr;
   logic        ram_re;
   logic [31:0] ram_data;
   logic        handshakeFPGA;
   logic        handshakePC;
   logic [31:0] dout;
   logic        dout_valid, dout_last, dout_ready;
   logic [31:0] frame_count, word_count;
   logic        busy, len_error;

   tdc_ram_reader #(.ADDR_W(8), .DATA_W(32)) dut (
      .SYSCLK(SYSCLK), .RESET_N(RESET_N),
      .ram_addr(ram_addr), .ram_re(ram_re), .ram_data(ram_data),
      .handshakeFPGA(handshakeFPGA), .handshakePC(handshakePC),
      .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
      .dout_ready(dout_ready), .frame_count(frame_count),
      .word_count(word_count), .busy(busy), .len_error(len_error)
   );

   always #5 SYSCLK = ~SYSCLK;

   logic [31:0] mem [0:255];
   logic [32:0] sb [$];
   int n_vec = 0, n_err = 0;
   int cyc = 0, n_pop = 0, last_pop_edge = 0, cur_n = 0, max_addr = 0;
   logic        prev_hold = 1'b0, prev_last = 1'b0;
   logic [31:0] prev_dout = '0;

   // Synchronous read port: data one cycle after ram_re.
   always @(posedge SYSCLK) if (ram_re) ram_data <= mem[ram_addr];
   always @(posedge SYSCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: address range, stall stability, scoreboard compare.
   always @(negedge SYSCLK) begin
      if (!RESET_N) begin
         prev_hold = 1'b0;
      end else begin
         if (ram_re) begin
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            check("addr_range", 64'(int'(ram_addr) <= cur_n), 64'(1));
         end
         if (prev_hold)
            check("stall_hold", 64'({dout_valid, dout_last, dout}), 64'({1'b1, prev_last, prev_dout}));
         if (dout_valid && dout_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) check("dout", 64'({dout_last, dout}), 64'(sb.pop_front()));
            n_pop++;
            if (dout_last) last_pop_edge = cyc + 1;
         end
         prev_hold = dout_valid && !dout_ready;
         prev_dout = dout;
         prev_last = dout_last;
      end
   end

   task automatic load_frame(input logic [31:0] hdr, input int n, input bit rnd);
      logic [31:0] d;
      mem[0] = hdr;
      for (int i = 1; i <= n; i++) begin
         d = rnd ? $urandom : 32'hA0 + 32'(i);
         mem[i] = d;
         sb.push_back({i == n, d});
      end
      cur_n = n;
      max_addr = 0;
   endtask

   // Raise the request and run until handshakePC appears (bounded).
   task automatic run_frame(input int pat, input int budget, input int drop_at);
      bit seen = 1'b0;
      handshakeFPGA = 1'b1;
      for (int k = 0; k < budget; k++) begin
         case (pat)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (k % 3 == 0);
            default: dout_ready = 1'($urandom_range(0, 1));
         endcase
         if (k == drop_at) handshakeFPGA = 1'b0;
         @(posedge SYSCLK); #1;
         if (handshakePC) begin seen = 1'b1; break; end
      end
      check("pc_seen", 64'(seen), 64'(1));
      check("sb_drained", 64'(sb.size()), 64'(0));
      if (cur_n > 0) check("pc_latency", 64'((cyc - last_pop_edge) <= 2), 64'(1));
   endtask

   task automatic drop_hs;
      handshakeFPGA = 1'b0;
      @(posedge SYSCLK); #1;
      check("pc_drop", 64'(handshakePC), 64'(0));
      check("idle_after", 64'(busy), 64'(0));
   endtask

   initial begin
      int c3, start;
      RESET_N = 1'b0; handshakeFPGA = 1'b0; dout_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge SYSCLK);
      #1;
      check("rst_ctl", 64'({ram_re, ram_addr, handshakePC, dout_valid, dout_last, busy, len_error}), 64'(0));
      check("rst_dout", 64'(dout), 64'(0));
      check("rst_cnt", {frame_count, word_count}, 64'(0));
      RESET_N = 1'b1;
      @(posedge SYSCLK); #1;

      // N=4, always ready: 4-cycle start latency, back-to-back words.
      load_frame(32'd4, 4, 1'b0);
      handshakeFPGA = 1'b1; dout_ready = 1'b1;
      repeat (3) @(posedge SYSCLK);
      #1;
      check("t1_not_yet", 64'(dout_valid), 64'(0));
      @(posedge SYSCLK); #1;
      c3 = cyc;
      check("t1_first", 64'({dout_valid, dout}), 64'({1'b1, 32'hA1}));
      run_frame(0, 50, -1);
      check("t1_burst", 64'(last_pop_edge), 64'(c3 + 4));
      check("t1_counts", {frame_count, word_count}, {32'd1, 32'd4});
      drop_hs();

      // N=0: acknowledge with no data.
      load_frame(32'd0, 0, 1'b0);
      run_frame(0, 50, -1);
      drop_hs();
      check("t2_counts", {frame_count, word_count}, {32'd2, 32'd4});

      // N=255 with ready 1,0,0 pattern.
      load_frame(32'd255, 255, 1'b1);
      run_frame(1, 1200, -1);
      check("t3_maxaddr", 64'(max_addr), 64'(255));
      check("t3_counts", {frame_count, word_count}, {32'd3, 32'd259});
      check("t3_lenerr", 64'(len_error), 64'(0));
      drop_hs();

      // Oversized header is clamped to 255 words.
      load_frame(32'h0000_0100, 255, 1'b1);
      run_frame(0, 600, -1);
      check("t4_lenerr", 64'(len_error), 64'(1));
      check("t4_maxaddr", 64'(max_addr), 64'(255));
      check("t4_counts", {frame_count, word_count}, {32'd4, 32'd514});
      drop_hs();

      // Reset in the middle of a frame, then restart from the header.
      load_frame(32'd20, 20, 1'b1);
      handshakeFPGA = 1'b1; dout_ready = 1'b1;
      start = n_pop;
      for (int k = 0; k < 200 && (n_pop - start) < 10; k++) begin
         @(posedge SYSCLK); #1;
      end
      check("t5_ten_words", 64'(n_pop - start), 64'(10));
      RESET_N = 1'b0;
      #1;
      check("t5_async_ctl", 64'({ram_re, dout_valid, dout_last, handshakePC, busy, len_error}), 64'(0));
      check("t5_async_data", {dout, word_count}, 64'(0));
      check("t5_async_fc", 64'(frame_count), 64'(0));
      sb.delete();
      load_frame(32'd20, 20, 1'b1);
      @(posedge SYSCLK); #1;
      RESET_N = 1'b1;
      run_frame(0, 200, -1);
      check("t5_counts", {frame_count, word_count}, {32'd1, 32'd20});
      drop_hs();

      // Three back-to-back frames; the last drops its request mid-frame.
      for (int f = 0; f < 3; f++) begin
         load_frame(32'(3 + 2 * f), 3 + 2 * f, 1'b1);
         run_frame(2, 300, (f == 2) ? 3 : -1);
         drop_hs();
         @(posedge SYSCLK); #1;
         check("t6_pc_quiet", 64'(handshakePC), 64'(0));
      end
      check("t6_counts", {frame_count, word_count}, {32'd4, 32'd35});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tdc_ram_reader.md
Name: tdc_ram_reader

Overview:
- Consumer end of the TDC data-channel DPRAM handoff.
- The data channel writes a frame into the 256-word DPRAM, then raises handshakeFPGA. This block reads that frame through the DPRAM read port and streams it out on a valid/ready interface.
- When the frame has been read, the block raises handshakePC so the channel can reuse the buffer.
- One instance per channel, on the SYSCLK (192 MHz) domain.

Parameters:
- ADDR_W, 8: DPRAM address width; depth is 2^ADDR_W.
- DATA_W, 32: DPRAM word width.

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- ram_addr  out  ADDR_W  DPRAM read address.
- ram_re  out  1  DPRAM read enable; ram_data is valid exactly 1 cycle after ram_re.
- ram_data  in  DATA_W  DPRAM read data.
- handshakeFPGA  in  1  frame-ready request from the data channel (same clock domain).
- handshakePC  out  1  frame-consumed acknowledge to the data channel.
- dout  out  DATA_W  streamed data word.
- dout_valid  out  1  dout is valid.
- dout_last  out  1  final word of the frame; qualified by dout_valid.
- dout_ready  in  1  downstream accepts a word.
- frame_count  out  32  number of frames completed (ACK issued); wraps modulo 2^32.
- word_count  out  32  total data words transferred; wraps modulo 2^32.
- busy  out  1  high in any state other than IDLE.
- len_error  out  1  sticky flag: a header length exceeded 2^ADDR_W-1.

Behaviour:
- Reset: all outputs 0, counters 0, output FIFO empty, FSM in IDLE.
- Frame format: address 0 is the header; header[ADDR_W-1:0] = N, the number of data words. Data words sit at addresses 1..N.
- Clamping: if header bits [DATA_W-1:ADDR_W] are nonzero, N is clamped to 2^ADDR_W-1 and len_error is set. len_error clears only on reset.
- Handshake is 4-phase:
  - handshakeFPGA rises; reader streams the frame; reader raises handshakePC.
  - Writer drops handshakeFPGA; reader drops handshakePC.
  - Reader waits for handshakeFPGA low before starting the next frame.
- FSM:
  - IDLE: if handshakeFPGA=1, assert ram_re with ram_addr=0, go to HDR.
  - HDR: capture N from ram_data. If N=0, go to ACK; otherwise go to STREAM with read pointer = 1.
  - STREAM: issue reads for addresses 1..N in order; go to DRAIN after the read of address N is issued.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to ACK.
  - ACK: handshakePC=1 (registered); frame_count increments once on entry; go to WAIT_DROP.
  - WAIT_DROP: hold handshakePC=1 until handshakeFPGA=0. Then handshakePC goes 0 on the next edge; return to IDLE.
- Output buffering:
  - 2-entry FIFO between ram_data and dout.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2. Guarantees no overflow under any dout_ready pattern.
  - Sustains 1 word/cycle while dout_ready=1.
- Output rules:
  - dout and dout_last are stable while dout_valid=1 and dout_ready=0.
  - dout_last=1 only on the word read from address N.
  - word_count increments on each dout_valid&&dout_ready.
- Latency: handshakeFPGA rise to first dout_valid = 4 cycles (IDLE, HDR, first read, FIFO register). Last handshake (dout_valid&&dout_ready on the last word) to handshakePC=1 ≤ 2 cycles.
- Address range: ram_addr never exceeds N and does not wrap within a frame.
- Robustness:
  - handshakeFPGA dropping during STREAM or DRAIN is ignored; the frame completes.
  - handshakeFPGA already low on ACK entry: handshakePC pulses high for exactly 1 cycle.
- Reset mid-frame: outputs are immediately 0 and the FIFO is discarded. After RESET_N deasserts, a still-high handshakeFPGA starts a fresh read from address 0.

Test Plan:
- Frame N=4 (data 0xA1..0xA4), dout_ready=1 constant -> dout sequence A1..A4 on consecutive cycles, dout_last with A4, handshakePC=1 ≤2 cycles later; frame_count=1, word_count=4.
- Header N=0 -> no dout_valid; handshakePC asserts; after handshakeFPGA drops, handshakePC=0 next cycle; frame_count=1.
- N=255, dout_ready toggling 1,0,0,1,… -> all 255 words delivered in order with no loss or duplicates; dout held stable while stalled; ram_addr max 255; word_count=255.
- Header=0x00000100 -> len_error=1, exactly 255 words streamed, dout_last on word 255.
- RESET_N asserted low mid-STREAM after 10 words -> outputs 0 asynchronously; on release with handshakeFPGA still high, the frame restarts from the header and frame_count=1 at completion.
- 3 back-to-back frames with full 4-phase handshake -> frame_count=3; handshakePC never rises before handshakeFPGA has been low since the previous ACK.
